// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

   localparam int MD_WIDTH = 32;
   localparam int CNT_W    = 5;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIXUP
   } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on the
// {acc,lo} pair.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             i_div,
   input  logic [WIDTH:0]   i_acc,
   input  logic [WIDTH-1:0] i_lo,
   input  logic [WIDTH-1:0] i_opnd,
   output logic [WIDTH:0]   o_acc,
   output logic [WIDTH-1:0] o_lo_mul,
   output logic             o_qbit
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_add;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH+1:0] w_diff;

   // Multiply: acc stays below 2^WIDTH, so the extra acc bit only holds the carry.
   assign w_sum    = i_acc + {1'b0, i_opnd};
   assign w_add    = i_lo[0] ? w_sum : i_acc;
   assign o_lo_mul = {w_add[0], i_lo[WIDTH-1:1]};

   assign w_shift  = {i_acc[WIDTH-1:0], i_lo[WIDTH-1]};
   assign w_diff   = {1'b0, w_shift} - {2'b00, i_opnd};
   assign o_qbit   = ~w_diff[WIDTH+1];

   always_comb begin
      o_acc = {1'b0, w_add[WIDTH:1]};
      if (i_div) begin
         o_acc = o_qbit ? w_diff[WIDTH:0] : w_shift;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller holding the architectural HI/LO
// registers; stalls the pipeline only when the unit or HI/LO is needed while busy.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             flush,
   input  logic             hilo_rd,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   md_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_pl;
   logic [WIDTH-1:0] r_opnd;
   logic [WIDTH-1:0] r_srca;
   logic             r_div;
   logic             r_signed;
   logic             r_sign_b;
   logic             r_bzero;

   muldiv_op_t       w_op;
   logic             w_accept;
   logic             w_is_signed;
   logic             w_is_div;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;
   logic [WIDTH:0]   w_step_acc;
   logic [WIDTH-1:0] w_step_lo;
   logic             w_qbit;
   logic             w_neg_q;
   logic             w_neg_r;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0] w_quot;
   logic [WIDTH-1:0] w_rem;

   assign w_op        = muldiv_op_t'(op);
   assign w_accept    = start & ~flush & (r_state == ST_IDLE) & (w_op != OP_NONE);
   assign w_is_signed = (w_op == OP_MULT) | (w_op == OP_DIV);
   assign w_is_div    = (w_op == OP_DIV) | (w_op == OP_DIVU);
   assign w_mag_a     = (w_is_signed & srca[WIDTH-1]) ? -srca : srca;
   assign w_mag_b     = (w_is_signed & srcb[WIDTH-1]) ? -srcb : srcb;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_div    (r_div),
      .i_acc    (r_acc),
      .i_lo     (r_pl),
      .i_opnd   (r_opnd),
      .o_acc    (w_step_acc),
      .o_lo_mul (w_step_lo),
      .o_qbit   (w_qbit)
   );

   // The iteration ran on magnitudes; restore signs before committing.
   assign w_neg_q = r_signed & (r_srca[WIDTH-1] ^ r_sign_b);
   assign w_neg_r = r_signed & r_srca[WIDTH-1];
   assign w_prod  = w_neg_q ? -{r_acc[WIDTH-1:0], r_pl} : {r_acc[WIDTH-1:0], r_pl};
   assign w_quot  = w_neg_q ? -r_pl : r_pl;
   assign w_rem   = w_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_acc    <= '0;
         r_pl     <= '0;
         r_opnd   <= '0;
         r_srca   <= '0;
         r_div    <= 1'b0;
         r_signed <= 1'b0;
         r_sign_b <= 1'b0;
         r_bzero  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (w_op)
                     OP_MTHI: r_hi <= srca;
                     OP_MTLO: r_lo <= srca;
                     OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        r_state  <= ST_CALC;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_pl     <= w_is_div ? w_mag_a : w_mag_b;
                        r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
                        r_srca   <= srca;
                        r_div    <= w_is_div;
                        r_signed <= w_is_signed;
                        r_sign_b <= srcb[WIDTH-1];
                        r_bzero  <= (srcb == '0);
                     end
                     default: ;
                  endcase
               end
            end
            ST_CALC: begin
               r_acc <= w_step_acc;
               r_pl  <= r_div ? {r_pl[WIDTH-2:0], w_qbit} : w_step_lo;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_CNT) begin
                  r_state <= ST_FIXUP;
               end
            end
            ST_FIXUP: begin
               if (r_div && r_bzero) begin
                  r_hi <= r_srca;
                  r_lo <= '1;
               end else if (r_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quot;
               end else begin
                  {r_hi, r_lo} <= w_prod;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign stall = r_busy & (start | hilo_rd);
   assign busy  = r_busy;
   assign done  = r_done;
   assign hi    = r_hi;
   assign lo    = r_lo;

endmodule
